// File: rtl/mips_run_ctrl.sv
// ---------------------------------------------------------------------------
// mips_run_ctrl
//
// Run controller for the single-cycle MIPS core. It holds the core in reset
// for RESET_CYCLES cycles, releases it, and counts the cycles it executes.
// When the core PC equals the stop address, the controller freezes the core
// before that instruction executes. It then streams a window of
// data-memory words out over a valid/ready dump port.
//
// Optional build macro:
//   MIPS_RUN_CTRL_WATCHDOG_EN - if defined, RUN is ended after MAX_CYCLES
//                               counted cycles, with timeout set.
//                               If undefined, there is no watchdog and
//                               timeout is tied low.
//
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   start                   one-cycle run request (accepted in IDLE/DONE)
//   end_pc                  stop address, latched when start is accepted
//   cpu_pc                  current core PC
//   cpu_reset, cpu_en       core reset and core clock enable
//   dmem_addr, dmem_rdata   data-memory read port (combinational read)
//   dump_valid, dump_ready  dump handshake
//   dump_data, dump_idx     dumped word and its 0-based position
//   cycle_count             core cycles executed since release (saturating)
//   busy, done, timeout     run status
// ---------------------------------------------------------------------------
module mips_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 3,
    parameter int unsigned DUMP_BASE    = 50,
    parameter int unsigned DUMP_COUNT   = 21,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned MAX_CYCLES   = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      end_pc,
    input  logic [31:0]      cpu_pc,
    output logic             cpu_reset,
    output logic             cpu_en,
    output logic [31:0]      dmem_addr,
    input  logic [31:0]      dmem_rdata,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [31:0]      dump_data,
    output logic [7:0]       dump_idx,
    output logic [CNT_W-1:0] cycle_count,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned HOLD_W = 8;

    // Elaboration-time parameter range checks
    if (RESET_CYCLES < 1 || RESET_CYCLES > 255) begin : g_bad_reset_cycles
        $error("mips_run_ctrl: RESET_CYCLES out of range 1..255");
    end
    if (DUMP_COUNT < 1 || DUMP_COUNT > 255) begin : g_bad_dump_count
        $error("mips_run_ctrl: DUMP_COUNT out of range 1..255");
    end
    if (MAX_CYCLES < 1) begin : g_bad_max_cycles
        $error("mips_run_ctrl: MAX_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HOLD = 3'd1,
        S_RUN  = 3'd2,
        S_DUMP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [31:0]         end_pc_q;
    logic [HOLD_W-1:0]   hold_cnt;

    logic                start_acc;
    logic                hold_last;
    logic                pc_hit;
    logic                wd_hit;
    logic                beat_acc;
    logic                dump_last;

    // Status terms shared by the next-state and output logic
    assign start_acc = start && (state == S_IDLE || state == S_DONE);
    assign hold_last = (hold_cnt == HOLD_W'(RESET_CYCLES - 1));
    assign pc_hit    = (state == S_RUN) && (cpu_pc == end_pc_q);
    assign beat_acc  = dump_valid && dump_ready;
    assign dump_last = (dump_idx == IDX_W'(DUMP_COUNT - 1));

`ifdef MIPS_RUN_CTRL_WATCHDOG_EN
    // Watchdog fires on the RUN cycle where MAX_CYCLES have been counted
    assign wd_hit = (state == S_RUN) && (cycle_count == CNT_W'(MAX_CYCLES));
`else
    assign wd_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_last) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // A PC match takes priority; the watchdog only adds another exit
                if (pc_hit || wd_hit) begin
                    state_nxt = S_DUMP;
                end
            end
            S_DUMP: begin
                if (dump_ready && dump_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nxt = S_HOLD;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; cpu_en drops in the same cycle as the stop condition
    always_comb begin
        cpu_reset  = 1'b0;
        cpu_en     = 1'b0;
        dump_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                cpu_reset = 1'b1;
            end
            S_HOLD: begin
                cpu_reset = 1'b1;
                busy      = 1'b1;
            end
            S_RUN: begin
                cpu_en = !pc_hit && !wd_hit;
                busy   = 1'b1;
            end
            S_DUMP: begin
                dump_valid = 1'b1;
                busy       = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                cpu_reset = 1'b1;
            end
        endcase
    end

    // Run datapath: stop address, hold counter, cycle counter, dump index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            end_pc_q    <= '0;
            hold_cnt    <= '0;
            cycle_count <= '0;
            dump_idx    <= '0;
        end else if (start_acc) begin
            end_pc_q    <= end_pc;
            hold_cnt    <= '0;
            cycle_count <= '0;
            dump_idx    <= '0;
        end else begin
            if (state == S_HOLD && !hold_last) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            // Only executed cycles count; the counter saturates at all-ones
            if (cpu_en && (cycle_count != {CNT_W{1'b1}})) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            // The index stays on the last beat so DONE reports the final position
            if (beat_acc && !dump_last) begin
                dump_idx <= dump_idx + IDX_W'(1);
            end
        end
    end

`ifdef MIPS_RUN_CTRL_WATCHDOG_EN
    logic timeout_q;

    // Sticky timeout flag, cleared by the next accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (start_acc) begin
            timeout_q <= 1'b0;
        end else if (wd_hit && !pc_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Dump window addressing; the read data passes straight through
    assign dmem_addr = ADDR_W'(DUMP_BASE) + ADDR_W'(dump_idx);
    assign dump_data = dmem_rdata;

endmodule
